down_timer: RTL and testbench

Synchronous, loadable down-counter with terminal-count pulse and optional auto-reload. It complements the ripple up-counter: it counts down from a programmed value to zero, then stops or reloads. Intended use is as a programmable interval/timeout generator beside the existing counters. All state updates on one clock edge; there is no ripple clocking.

---
 rtl/down_timer.sv | 80 ++++++++
 tb/tb_down_timer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
// down_timer: loadable down-counter with terminal-count pulse
// and optional auto-reload; all outputs are registered.
module down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             reload_mode,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rl_q, rl_d;
  logic             tc_q, tc_d;

  logic             dec;
  logic             last;

  assign dec  = !load && (state_q == COUNT) && en;
  assign last = (q_q == WIDTH'(1));

  // next state: load beats decrement beats hold; tc only on terminal edge
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rl_d    = rl_q;
    tc_d    = 1'b0;
    unique case (1'b1)
      load: begin
        rl_d    = load_val;
        q_d     = load_val;
        state_d = (load_val != '0) ? COUNT : IDLE;
      end
      dec && last: begin
        tc_d = 1'b1;
        if (reload_mode) begin
          q_d = rl_q;
        end else begin
          q_d     = '0;
          state_d = IDLE;
        end
      end
      dec && !last: begin
        q_d = q_q - WIDTH'(1);
      end
      default: ;
    endcase
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      rl_q    <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rl_q    <= rl_d;
      tc_q    <= tc_d;
    end
  end

  assign q    = q_q;
  assign tc   = tc_q;
  assign busy = (state_q == COUNT);

endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: directed and random stimulus for down_timer
// against an integer reference model of the counting rules.
module tb_down_timer;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic         reload_mode;
  logic [W-1:0] q;
  logic         tc;
  logic         busy;

  int n_chk;
  int n_fail;

  int m_q;
  int m_rl;
  bit m_run;
  bit m_tc;

  down_timer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_val   (load_val),
    .en         (en),
    .reload_mode(reload_mode),
    .q          (q),
    .tc         (tc),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q   = 0;
    m_rl  = 0;
    m_run = 0;
    m_tc  = 0;
  endtask

  task automatic model_edge(input bit l, input int v,
                            input bit e, input bit rm);
    m_tc = 0;
    if (l) begin
      m_rl  = v;
      m_q   = v;
      m_run = (v != 0);
    end else if (m_run && e) begin
      if (m_q == 1) begin
        m_tc = 1;
        if (rm) m_q = m_rl;
        else begin
          m_q   = 0;
          m_run = 0;
        end
      end else begin
        m_q = m_q - 1;
      end
    end
  endtask

  task automatic check_model();
    chk("q", int'(q), m_q);
    chk("tc", int'(tc), int'(m_tc));
    chk("busy", int'(busy), int'(m_run));
  endtask

  // called at a falling edge; returns at the next falling edge
  task automatic step(input logic l, input logic [W-1:0] v,
                      input logic e, input logic rm);
    load        = l;
    load_val    = v;
    en          = e;
    reload_mode = rm;
    @(posedge clk);
    if (!reset) model_clear();
    else model_edge(l, int'(v), e, rm);
    #1;
    check_model();
    @(negedge clk);
  endtask

  // pulse reset between edges and check outputs drop at once
  task automatic async_reset(input string tag);
    #1;
    reset = 1'b0;
    #1;
    model_clear();
    chk({tag, "_q"}, int'(q), 0);
    chk({tag, "_tc"}, int'(tc), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    reset = 1'b1;
  endtask

  int seq3 [9] = '{3, 2, 1, 3, 2, 1, 3, 2, 1};
  int en_cnt;
  int tc_at;

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    model_clear();
    reset       = 1'b0;
    load        = 1'b0;
    load_val    = '0;
    en          = 1'b0;
    reload_mode = 1'b0;

    // reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      chk("rst_q", int'(q), 0);
      chk("rst_tc", int'(tc), 0);
      chk("rst_busy", int'(busy), 0);
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, W'($urandom), 1'b1, 1'($urandom));
      chk("idle_q", int'(q), 0);
      chk("idle_tc", int'(tc), 0);
    end

    // one-shot from 5
    step(1'b1, W'(5), 1'b1, 1'b0);
    chk("os_load_q", int'(q), 5);
    chk("os_load_busy", int'(busy), 1);
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, W'(0), 1'b1, 1'b0);
      chk("os_q", int'(q), 5 - i);
      chk("os_tc", int'(tc), (i == 5) ? 1 : 0);
      chk("os_busy", int'(busy), (i == 5) ? 0 : 1);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, W'(0), 1'b1, 1'b0);
      chk("os_after_q", int'(q), 0);
      chk("os_after_tc", int'(tc), 0);
    end

    // auto-reload from 3
    step(1'b1, W'(3), 1'b1, 1'b1);
    chk("ar_q", int'(q), seq3[0]);
    chk("ar_tc", int'(tc), 0);
    for (int i = 1; i < 9; i++) begin
      step(1'b0, W'(0), 1'b1, 1'b1);
      chk("ar_q", int'(q), seq3[i]);
      chk("ar_tc", int'(tc), (seq3[i] == 3) ? 1 : 0);
      chk("ar_busy", int'(busy), 1);
    end

    // enable gaps from max value
    step(1'b1, W'(15), 1'b0, 1'b0);
    en_cnt = 0;
    tc_at  = -1;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, W'(0), (i % 2) == 0, 1'b0);
      if ((i % 2) == 0) en_cnt++;
      if (tc && tc_at < 0) tc_at = en_cnt;
    end
    chk("gap_tc_edges", tc_at, 15);
    chk("gap_end_q", int'(q), 0);

    // terminal edge with en low yields no tc
    step(1'b1, W'(1), 1'b0, 1'b0);
    step(1'b0, W'(0), 1'b0, 1'b0);
    chk("noen_tc", int'(tc), 0);
    chk("noen_q", int'(q), 1);
    step(1'b0, W'(0), 1'b1, 1'b0);
    chk("en_tc", int'(tc), 1);

    // load priority
    step(1'b1, W'(5), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, W'(0), 1'b1, 1'b0);
    chk("lp_q2", int'(q), 2);
    step(1'b1, W'(7), 1'b1, 1'b0);
    chk("lp_q7", int'(q), 7);
    chk("lp_tc7", int'(tc), 0);
    for (int i = 0; i < 6; i++) step(1'b0, W'(0), 1'b1, 1'b0);
    chk("lp_q1", int'(q), 1);
    step(1'b1, W'(9), 1'b1, 1'b0);
    chk("lp_term_q", int'(q), 9);
    chk("lp_term_tc", int'(tc), 0);
    step(1'b1, W'(0), 1'b1, 1'b1);
    chk("lp_zero_q", int'(q), 0);
    chk("lp_zero_busy", int'(busy), 0);
    chk("lp_zero_tc", int'(tc), 0);

    // reset mid-count at q=4
    step(1'b1, W'(6), 1'b1, 1'b0);
    step(1'b0, W'(0), 1'b1, 1'b0);
    step(1'b0, W'(0), 1'b1, 1'b0);
    chk("mid_q4", int'(q), 4);
    async_reset("mid");
    for (int i = 0; i < 4; i++) begin
      step(1'b0, W'($urandom), 1'b1, 1'b1);
      chk("post_rst_q", int'(q), 0);
      chk("post_rst_busy", int'(busy), 0);
    end

    // reset while tc is high
    step(1'b1, W'(2), 1'b1, 1'b1);
    step(1'b0, W'(0), 1'b1, 1'b1);
    step(1'b0, W'(0), 1'b1, 1'b1);
    chk("tch_tc", int'(tc), 1);
    async_reset("tch");
    step(1'b0, W'(0), 1'b1, 1'b1);
    chk("tch_idle_q", int'(q), 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(63) == 0) async_reset("rnd");
      step($urandom_range(9) == 0,
           ($urandom_range(1) == 0) ? W'($urandom_range(4))
                                    : W'($urandom),
           $urandom_range(3) != 0,
           1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
